// File: rtl/cim_pkg.sv
// Shared types and width helpers for the CIM command sequencer.
package cim_pkg;

    typedef enum logic [1:0] {
        OP_MAC   = 2'b00,
        OP_WRITE = 2'b01,
        OP_QUERY = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_WRITE,
        ST_QUERY,
        ST_DONE
    } state_e;

    localparam int LEN_W  = 8;
    localparam int BEAT_W = 8;

    localparam logic IDLE_MAC_EN = 1'b1;
    localparam logic IDLE_W_EN   = 1'b0;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One counter serves both the MAC hold and the remaining-beat count.
    function automatic int cnt_w(input int mac_cycles);
        int w;
        w = $clog2(mac_cycles + 1);
        return (w > LEN_W) ? w : LEN_W;
    endfunction

endpackage

// File: rtl/cim_onehot_dec.sv
// Binary index to one-hot select decoder used for bank and column selects.
module cim_onehot_dec
    import cim_pkg::*;
#(
    parameter int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic [W-1:0] bin_i,
    output logic [N-1:0] onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[bin_i] = 1'b1;
    end

endmodule

// File: rtl/cim_array_seq.sv
// Command sequencer driving the CIM bank array for MAC, WRITE and QUERY.
// Define CIM_BURST_WRITE_EN to enable multi-beat writes with address auto-increment.
module cim_array_seq
    import cim_pkg::*;
#(
    parameter int N_BANK     = 16,
    parameter int N_ROW      = 4,
    parameter int N_COL      = 8,
    parameter int DATA_W     = 16,
    parameter int QUERY_W    = 4,
    parameter int MAC_CYCLES = 2,
    localparam int BANK_W = idx_w(N_BANK),
    localparam int ROW_W  = idx_w(N_ROW),
    localparam int COL_W  = idx_w(N_COL),
    localparam int ADDR_W = BANK_W + ROW_W + COL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DATA_W-1:0]   cmd_data_bank,
    input  logic [DATA_W-1:0]   cmd_data_in,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                mac_en,
    output logic                w_en,
    output logic [N_BANK-1:0]   bank_mux,
    output logic [ROW_W-1:0]    addr_row,
    output logic [N_COL-1:0]    col_mux,
    output logic [DATA_W-1:0]   data_op,
    output logic [DATA_W-1:0]   data_and,
    output logic [QUERY_W-1:0]  query_bar,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = cnt_w(MAC_CYCLES);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                cmd_ready_q;
    logic                wr_ready_q;
    logic                mac_en_q;
    logic                w_en_q;
    logic [N_BANK-1:0]   bank_mux_q;
    logic [ROW_W-1:0]    addr_row_q;
    logic [N_COL-1:0]    col_mux_q;
    logic [DATA_W-1:0]   data_op_q;
    logic [DATA_W-1:0]   data_and_q;
    logic [QUERY_W-1:0]  query_bar_q;
    logic                busy_q;
    logic                done_q;

    logic [N_BANK-1:0]   bank_onehot;
    logic [N_COL-1:0]    col_onehot;
    logic                cmd_fire;
    logic                beat_fire;
    logic                last_beat;
    logic                unused_bits;

    cim_onehot_dec #(.N(N_BANK)) u_bank_dec (
        .bin_i    (addr_q[ADDR_W-1 -: BANK_W]),
        .onehot_o (bank_onehot)
    );

    cim_onehot_dec #(.N(N_COL)) u_col_dec (
        .bin_i    (cmd_addr[COL_W-1:0]),
        .onehot_o (col_onehot)
    );

    assign cmd_fire  = cmd_valid && cmd_ready_q;
    assign beat_fire = wr_valid && wr_ready_q;

`ifdef CIM_BURST_WRITE_EN
    assign last_beat   = (cnt_q == '0);
    assign unused_bits = ^wr_data;
`else
    assign last_beat   = 1'b1;
    assign unused_bits = ^{wr_data, cmd_len, addr_q[COL_W-1:0]};
`endif

    // Outputs default to the idle drive every cycle; each state re-asserts what it needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            mac_en_q    <= IDLE_MAC_EN;
            w_en_q      <= IDLE_W_EN;
            bank_mux_q  <= '0;
            addr_row_q  <= '0;
            col_mux_q   <= '0;
            data_op_q   <= '0;
            data_and_q  <= '0;
            query_bar_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            mac_en_q    <= IDLE_MAC_EN;
            w_en_q      <= IDLE_W_EN;
            bank_mux_q  <= '0;
            addr_row_q  <= '0;
            col_mux_q   <= '0;
            data_op_q   <= '0;
            data_and_q  <= '0;
            query_bar_q <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    busy_q <= cmd_fire;
                    if (!cmd_fire) begin
                        cmd_ready_q <= 1'b1;
                    end else begin
                        addr_q <= cmd_addr;
                        case (op_e'(cmd_op))
                            OP_MAC: begin
                                state_q    <= ST_MAC;
                                cnt_q      <= CNT_W'(MAC_CYCLES - 1);
                                bank_mux_q <= '1;
                                col_mux_q  <= '1;
                                data_op_q  <= cmd_data_bank;
                                data_and_q <= cmd_data_in;
                            end
                            OP_WRITE: begin
                                state_q    <= ST_WRITE;
                                wr_ready_q <= 1'b1;
`ifdef CIM_BURST_WRITE_EN
                                cnt_q      <= CNT_W'(cmd_len);
`else
                                cnt_q      <= '0;
`endif
                            end
                            OP_QUERY: begin
                                state_q     <= ST_QUERY;
                                mac_en_q    <= 1'b0;
                                bank_mux_q  <= '1;
                                col_mux_q   <= col_onehot;
                                data_op_q   <= DATA_W'(cmd_data_bank[QUERY_W-1:0]);
                                data_and_q  <= '1;
                                query_bar_q <= ~cmd_data_bank[QUERY_W-1:0];
                            end
                            default: begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_MAC: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_q - CNT_W'(1);
                        bank_mux_q <= '1;
                        col_mux_q  <= '1;
                        data_op_q  <= data_op_q;
                        data_and_q <= data_and_q;
                    end
                end

                ST_QUERY: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end

                // The last beat drops wr_ready; the following cycle moves on to DONE.
                ST_WRITE: begin
                    if (beat_fire) begin
                        w_en_q     <= 1'b1;
                        bank_mux_q <= bank_onehot;
                        addr_row_q <= addr_q[COL_W +: ROW_W];
                        data_op_q  <= DATA_W'(wr_data[BEAT_W-1:0]);
                        if (!last_beat) begin
                            wr_ready_q <= 1'b1;
                            cnt_q      <= cnt_q - CNT_W'(1);
`ifdef CIM_BURST_WRITE_EN
                            addr_q     <= addr_q + ADDR_W'(1);
`endif
                        end
                    end else if (wr_ready_q) begin
                        wr_ready_q <= 1'b1;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign mac_en    = mac_en_q;
    assign w_en      = w_en_q;
    assign bank_mux  = bank_mux_q;
    assign addr_row  = addr_row_q;
    assign col_mux   = col_mux_q;
    assign data_op   = data_op_q;
    assign data_and  = data_and_q;
    assign query_bar = query_bar_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cim_array_seq.sv
// Scoreboard bench for cim_array_seq: expected per-cycle drive is queued with each command.
// Expectations follow CIM_BURST_WRITE_EN when it is defined for the build.
module tb_cim_array_seq;

`ifdef CIM_BURST_WRITE_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct packed {
        logic        cmd_ready;
        logic        wr_ready;
        logic        busy;
        logic        done;
        logic        mac_en;
        logic        w_en;
        logic [15:0] bank_mux;
        logic [1:0]  addr_row;
        logic [7:0]  col_mux;
        logic [15:0] data_op;
        logic [15:0] data_and;
        logic [3:0]  query_bar;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [15:0] cmd_data_bank;
    logic [15:0] cmd_data_in;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        mac_en;
    logic        w_en;
    logic [15:0] bank_mux;
    logic [1:0]  addr_row;
    logic [7:0]  col_mux;
    logic [15:0] data_op;
    logic [15:0] data_and;
    logic [3:0]  query_bar;
    logic        busy;
    logic        done;

    obs_t  expQ[$];
    string tagQ[$];
    int    testCount = 0;
    int    failCount = 0;

    cim_array_seq #(
        .N_BANK(16), .N_ROW(4), .N_COL(8), .DATA_W(16), .QUERY_W(4), .MAC_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_data_bank(cmd_data_bank), .cmd_data_in(cmd_data_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .mac_en(mac_en), .w_en(w_en), .bank_mux(bank_mux), .addr_row(addr_row),
        .col_mux(col_mux), .data_op(data_op), .data_and(data_and),
        .query_bar(query_bar), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sampleObs();
        obs_t o;
        o = '{cmd_ready, wr_ready, busy, done, mac_en, w_en, bank_mux, addr_row,
              col_mux, data_op, data_and, query_bar};
        return o;
    endfunction

    function automatic obs_t mkIdle(input logic rdy, input logic bsy, input logic dn,
                                    input logic wrr);
        obs_t o;
        o           = '0;
        o.mac_en    = 1'b1;
        o.cmd_ready = rdy;
        o.busy      = bsy;
        o.done      = dn;
        o.wr_ready  = wrr;
        return o;
    endfunction

    function automatic obs_t mkBeat(input logic [15:0] bank, input logic [1:0] row,
                                    input logic [7:0] d, input logic wrr);
        obs_t o;
        o          = mkIdle(1'b0, 1'b1, 1'b0, wrr);
        o.w_en     = 1'b1;
        o.bank_mux = bank;
        o.addr_row = row;
        o.data_op  = {8'h00, d};
        return o;
    endfunction

    function automatic obs_t mkQuery(input logic [7:0] col, input logic [3:0] key);
        obs_t o;
        o           = mkIdle(1'b0, 1'b1, 1'b0, 1'b0);
        o.mac_en    = 1'b0;
        o.bank_mux  = 16'hFFFF;
        o.col_mux   = col;
        o.data_op   = {12'h000, key};
        o.data_and  = 16'hFFFF;
        o.query_bar = ~key;
        return o;
    endfunction

    task automatic push(input obs_t o, input string tag);
        expQ.push_back(o);
        tagQ.push_back(tag);
    endtask

    task automatic test_reset();
        obs_t got, want;
        string tag;
        rst = 1'b1;
        push(mkIdle(1'b0, 1'b0, 1'b0, 1'b0), "reset_hold0");
        push(mkIdle(1'b0, 1'b0, 1'b0, 1'b0), "reset_hold1");
        push(mkIdle(1'b1, 1'b0, 1'b0, 1'b0), "reset_release");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            got = sampleObs(); want = expQ.pop_front(); tag = tagQ.pop_front();
            testCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL %s: got %h want %h", tag, got, want);
            end
            if (i == 1) rst = 1'b0;
        end
    endtask

    task automatic test_mac();
        obs_t got, want, m;
        string tag;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 9'h0AB;
        cmd_data_bank = 16'hA5A5; cmd_data_in = 16'h0F0F;
        m = mkIdle(1'b0, 1'b1, 1'b0, 1'b0);
        m.bank_mux = 16'hFFFF; m.col_mux = 8'hFF; m.data_op = 16'hA5A5; m.data_and = 16'h0F0F;
        push(m, "mac_cycle0");
        push(m, "mac_cycle1");
        push(mkIdle(1'b0, 1'b1, 1'b1, 1'b0), "mac_done");
        push(mkIdle(1'b1, 1'b0, 1'b0, 1'b0), "mac_idle");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            got = sampleObs(); want = expQ.pop_front(); tag = tagQ.pop_front();
            testCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL %s: got %h want %h", tag, got, want);
            end
            cmd_valid = 1'b0;
        end
    endtask

    task automatic test_query();
        obs_t got, want;
        string tag;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 9'h075;
        cmd_data_bank = 16'hBEEA; cmd_data_in = 16'h1234;
        push(mkQuery(8'h20, 4'b1010), "query_drive");
        push(mkIdle(1'b0, 1'b1, 1'b1, 1'b0), "query_done");
        push(mkIdle(1'b1, 1'b0, 1'b0, 1'b0), "query_idle");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            got = sampleObs(); want = expQ.pop_front(); tag = tagQ.pop_front();
            testCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL %s: got %h want %h", tag, got, want);
            end
            cmd_valid = 1'b0;
        end
    endtask

    task automatic test_write_burst();
        obs_t got, want;
        string tag;
        logic       wrV[7];
        logic [7:0] wrD[7];
        wrV = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        wrD = '{8'h11, 8'h00, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 9'h1FF; cmd_len = 8'd2;
        push(mkIdle(1'b0, 1'b1, 1'b0, 1'b1), "wr_wait");
        push(mkBeat(16'h8000, 2'd3, 8'h11, BURST), "wr_beat_1ff");
        if (BURST) begin
            push(mkIdle(1'b0, 1'b1, 1'b0, 1'b1), "wr_gap");
            push(mkBeat(16'h0001, 2'd0, 8'h22, 1'b1), "wr_beat_wrap0");
            push(mkBeat(16'h0001, 2'd0, 8'h33, 1'b0), "wr_beat_addr1");
            push(mkIdle(1'b0, 1'b1, 1'b1, 1'b0), "wr_done");
            push(mkIdle(1'b1, 1'b0, 1'b0, 1'b0), "wr_idle");
        end else begin
            push(mkIdle(1'b0, 1'b1, 1'b1, 1'b0), "wr_done");
            push(mkIdle(1'b1, 1'b0, 1'b0, 1'b0), "wr_idle_ignore0");
            push(mkIdle(1'b1, 1'b0, 1'b0, 1'b0), "wr_idle_ignore1");
            push(mkIdle(1'b1, 1'b0, 1'b0, 1'b0), "wr_idle_ignore2");
            push(mkIdle(1'b1, 1'b0, 1'b0, 1'b0), "wr_idle_ignore3");
        end
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            got = sampleObs(); want = expQ.pop_front(); tag = tagQ.pop_front();
            testCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL %s: got %h want %h", tag, got, want);
            end
            cmd_valid = 1'b0;
            wr_valid  = wrV[i];
            wr_data   = {8'hFF, wrD[i]};
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        obs_t got, want;
        string tag;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 9'h048; cmd_len = 8'd3;
        push(mkIdle(1'b0, 1'b1, 1'b0, 1'b1), "rstmid_wait");
        push(mkBeat(16'h0004, 2'd1, 8'h44, BURST), "rstmid_beat");
        push(mkIdle(1'b0, 1'b0, 1'b0, 1'b0), "rstmid_reset");
        push(mkIdle(1'b1, 1'b0, 1'b0, 1'b0), "rstmid_release");
        push(mkIdle(1'b1, 1'b0, 1'b0, 1'b0), "rstmid_no_done");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            got = sampleObs(); want = expQ.pop_front(); tag = tagQ.pop_front();
            testCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL %s: got %h want %h", tag, got, want);
            end
            if (i == 0) begin
                cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'h0044;
            end else if (i == 1) begin
                rst = 1'b1;
            end else if (i == 2) begin
                rst = 1'b0; wr_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, want;
        string tag;
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_addr = 9'h1C3; cmd_data_bank = 16'h0000;
        push(mkIdle(1'b0, 1'b1, 1'b1, 1'b0), "b2b_nop_done");
        push(mkIdle(1'b1, 1'b0, 1'b0, 1'b0), "b2b_ready");
        push(mkQuery(8'h01, 4'h3), "b2b_query");
        push(mkIdle(1'b0, 1'b1, 1'b1, 1'b0), "b2b_query_done");
        push(mkIdle(1'b1, 1'b0, 1'b0, 1'b0), "b2b_idle");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            got = sampleObs(); want = expQ.pop_front(); tag = tagQ.pop_front();
            testCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL %s: got %h want %h", tag, got, want);
            end
            if (i == 0) begin
                cmd_op = 2'b10; cmd_addr = 9'h1E0; cmd_data_bank = 16'h7773;
            end else if (i == 2) begin
                cmd_valid = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b11; cmd_addr = '0; cmd_len = '0;
        cmd_data_bank = '0; cmd_data_in = '0; wr_valid = 1'b0; wr_data = '0;
        test_reset();
        test_mac();
        test_query();
        test_write_burst();
        test_reset_mid_burst();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
